// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage vs. a buffered long-latency unit.
// Unit results queue in a FIFO and drain into idle port cycles, or steal the port after starvation.
module rf_write_arbiter #(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wbEn,
  input  logic [4:0]                wbAddr,
  input  logic [31:0]               wbData,
  output logic                      wbStall,
  input  logic                      muValid,
  input  logic [4:0]                muAddr,
  input  logic [31:0]               muData,
  output logic                      muReady,
  output logic                      rfWe,
  output logic [4:0]                rfAddr,
  output logic [31:0]               rfData,
  output logic [$clog2(QDEPTH):0]   qCount
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(QDEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [4:0]    addr_mem_q [QDEPTH];
  logic [31:0]   data_mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          empty_s;
  logic          head_grant_s;
  logic          enq_s;
  logic          mu_ready_s;
  logic          wb_stall_s;
  logic          rf_we_s;
  logic [4:0]    rf_addr_s;
  logic [31:0]   rf_data_s;
  logic [CW-1:0] q_count_s;
  logic [4:0]    head_addr_s;
  logic [31:0]   head_data_s;

  assign head_addr_s = addr_mem_q[rd_ptr_q];
  assign head_data_s = data_mem_q[rd_ptr_q];
  assign empty_s     = (count_q == {CW{1'b0}});

  // Port grant and output muxing; reset forces every output to zero
  always_comb begin
    mu_ready_s   = 1'b0;
    head_grant_s = 1'b0;
    wb_stall_s   = 1'b0;
    rf_we_s      = 1'b0;
    rf_addr_s    = 5'd0;
    rf_data_s    = 32'd0;
    q_count_s    = {CW{1'b0}};
    if (!rst) begin
      mu_ready_s = (count_q < FULL_CNT);
      q_count_s  = count_q;
      if (empty_s) begin
        rf_we_s   = wbEn && (wbAddr != 5'd0);
        rf_addr_s = wbAddr;
        rf_data_s = wbData;
      end else if (!wbEn || (starve_q == STARVE_LIM)) begin
        // Head takes the port; a pending WB write is held off for one cycle
        head_grant_s = 1'b1;
        wb_stall_s   = wbEn;
        rf_we_s      = (head_addr_s != 5'd0);
        rf_addr_s    = head_addr_s;
        rf_data_s    = head_data_s;
      end else begin
        rf_we_s   = (wbAddr != 5'd0);
        rf_addr_s = wbAddr;
        rf_data_s = wbData;
      end
    end else begin
      mu_ready_s = 1'b0;
    end
  end

  assign enq_s = muValid && mu_ready_s;

  // Next-state for pointers, occupancy and starvation counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (enq_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (head_grant_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({enq_s, head_grant_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (empty_s || head_grant_s) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      starve_q <= {SW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (!rst && enq_s) begin
      addr_mem_q[wr_ptr_q] <= muAddr;
      data_mem_q[wr_ptr_q] <= muData;
    end
  end

  assign wbStall = wb_stall_s;
  assign muReady = mu_ready_s;
  assign rfWe    = rf_we_s;
  assign rfAddr  = rf_addr_s;
  assign rfData  = rf_data_s;
  assign qCount  = q_count_s;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbEn = 1'b0;
  logic [4:0]  wbAddr = 5'd0;
  logic [31:0] wbData = 32'd0;
  logic        wbStall;
  logic        muValid = 1'b0;
  logic [4:0]  muAddr = 5'd0;
  logic [31:0] muData = 32'd0;
  logic        muReady;
  logic        rfWe;
  logic [4:0]  rfAddr;
  logic [31:0] rfData;
  logic [1:0]  qCount;

  int tests_run = 0;
  int tests_failed = 0;
  bit stim_done = 1'b0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk;
    logic        stall;
    logic        ready;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  rf_write_arbiter #(.QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData), .wbStall(wbStall),
    .muValid(muValid), .muAddr(muAddr), .muData(muData), .muReady(muReady),
    .rfWe(rfWe), .rfAddr(rfAddr), .rfData(rfData), .qCount(qCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic we, input logic [4:0] a, input logic [31:0] d,
                              input logic stall, input logic ready, input logic [1:0] cnt);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.chk = we;
    e.stall = stall; e.ready = ready; e.cnt = cnt;
    return e;
  endfunction

  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; wbEn = we; wbAddr = wa; wbData = wd;
    muValid = mv; muAddr = ma; muData = md;
    exp_q.push_back(e);
  endtask

  // Monitor: compare one expectation per cycle, mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rfWe", {31'd0, rfWe}, {31'd0, e.we});
        check("wbStall", {31'd0, wbStall}, {31'd0, e.stall});
        check("muReady", {31'd0, muReady}, {31'd0, e.ready});
        check("qCount", {30'd0, qCount}, {30'd0, e.cnt});
        if (e.chk) begin
          check("rfAddr", {27'd0, rfAddr}, {27'd0, e.addr});
          check("rfData", rfData, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus not finished, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset: outputs held at zero even with requests present
    step(1'b1, 1'b1, 5'd8, 32'h1111, 1'b1, 5'd3, 32'h3, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0));
    step(1'b1, 1'b1, 5'd8, 32'h1111, 1'b1, 5'd3, 32'h3, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0));
    // Idle pass-through
    step(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ex(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 1'b1, 2'd0));
    // Free-slot drain: no write in arrival cycle, head written next cycle
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h12345678, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b1, 5'd9, 32'h12345678, 1'b0, 1'b1, 2'd1));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    // Starvation: four WB wins, forced head grant with stall, held WB retried
    step(1'b0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA, ex(1'b1, 5'd1, 32'h100, 1'b0, 1'b1, 2'd0));
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, 1'b1, 5'(i), 32'(i * 256), 1'b0, 5'd0, 32'd0, ex(1'b1, 5'(i), 32'(i * 256), 1'b0, 1'b1, 2'd1));
    end
    step(1'b0, 1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'd0, ex(1'b1, 5'd10, 32'hA, 1'b1, 1'b1, 2'd1));
    step(1'b0, 1'b1, 5'd6, 32'h600, 1'b0, 5'd0, 32'd0, ex(1'b1, 5'd6, 32'h600, 1'b0, 1'b1, 2'd0));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    // Full / backpressure: third result held until a dequeue frees space
    step(1'b0, 1'b1, 5'd7, 32'h700, 1'b1, 5'd11, 32'hB, ex(1'b1, 5'd7, 32'h700, 1'b0, 1'b1, 2'd0));
    step(1'b0, 1'b1, 5'd13, 32'hD00, 1'b1, 5'd14, 32'hE, ex(1'b1, 5'd13, 32'hD00, 1'b0, 1'b1, 2'd1));
    step(1'b0, 1'b1, 5'd15, 32'hF00, 1'b1, 5'd16, 32'h10, ex(1'b1, 5'd15, 32'hF00, 1'b0, 1'b0, 2'd2));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h10, ex(1'b1, 5'd11, 32'hB, 1'b0, 1'b0, 2'd2));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h10, ex(1'b1, 5'd14, 32'hE, 1'b0, 1'b1, 2'd1));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b1, 5'd16, 32'h10, 1'b0, 1'b1, 2'd1));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    // $0: FIFO entry dequeued without a write; WB $0 write suppressed, not stalled
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd1));
    step(1'b0, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    // Reset mid-drain: queued entries discarded, no stale write afterwards
    step(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, ex(1'b1, 5'd1, 32'h1, 1'b0, 1'b1, 2'd0));
    step(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21, ex(1'b1, 5'd2, 32'h2, 1'b0, 1'b1, 2'd1));
    step(1'b1, 1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h22, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ex(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 2'd0));
    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the WB stage and a long-latency execution unit (multiply/divide, or another multi-cycle unit) that returns results out of pipeline order. Unit results are buffered in a small FIFO and drained into free write-port cycles. When the buffer has waited too long, the arbiter steals the port and stalls the WB stage. It sits between WB_Stage outputs and the register file write inputs.

## Interface
Parameters:
- QDEPTH, 2, unit result FIFO depth (power of two, ≥2)
- STARVE_MAX, 4, number of consecutive denied cycles for the FIFO head before a forced grant (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wbEn  in  1  WB stage write request
- wbAddr  in  5  WB destination register
- wbData  in  32  WB write data
- wbStall  out  1  WB write not taken this cycle; pipeline must hold WB and upstream
- muValid  in  1  unit result valid
- muAddr  in  5  unit destination register
- muData  in  32  unit result
- muReady  out  1  FIFO can accept a result this cycle
- rfWe  out  1  register file write enable
- rfAddr  out  5  register file write address
- rfData  out  32  register file write data
- qCount  out  $clog2(QDEPTH)+1  current FIFO occupancy

## Operation
- Reset: FIFO emptied, pointers 0, starveCnt 0. While rst=1: rfWe=0, wbStall=0, muReady=0, qCount=0, rfAddr=0, rfData=0.
- Enqueue: fires on the clk edge when muValid && muReady. muReady = (qCount < QDEPTH), evaluated on start-of-cycle occupancy.
  - When full, muReady=0 even if a dequeue occurs the same cycle. There is no full pass-through.
- There is no bypass. A unit result is never written in its arrival cycle. Its earliest write is the next cycle.
- Grant, combinational each cycle, with head = FIFO head entry:
  - Queue empty: WB path. rfWe=wbEn, rfAddr=wbAddr, rfData=wbData, wbStall=0.
  - Queue non-empty and wbEn=0: head is written, dequeued at the edge, wbStall=0.
  - Queue non-empty, wbEn=1, starveCnt < STARVE_MAX: WB wins and the head waits. wbStall=0.
  - Queue non-empty, wbEn=1, starveCnt == STARVE_MAX: head wins, dequeued at the edge. wbStall=1, and WB presents identical inputs next cycle.
- Destination $0:
  - A granted write with address 0 drives rfWe=0.
  - A $0 FIFO entry is still dequeued.
  - A $0 WB write still consumes its slot, so it is not stalled for that reason.
- starveCnt, width $clog2(STARVE_MAX+1):
  - Increments when the queue is non-empty, wbEn=1 and WB is granted.
  - Clears to 0 on any head grant or when the queue is empty.
  - Never exceeds STARVE_MAX.
- qCount: +1 on enqueue, −1 on dequeue, unchanged when both or neither occur.
- Read/write pointers wrap modulo QDEPTH.
- No WAW address comparison is performed. The ID-stage scoreboard guarantees that a queued destination is never targeted by an in-flight pipeline instruction.

## Timing
- WB path: zero-latency combinational pass-through (wbEn→rfWe, same cycle).
- Unit path: minimum 1 cycle from accept to rfWe.
  - Worst case with queue depth d ahead of it: (d+1)·(STARVE_MAX+1) cycles under continuous wbEn.
- wbStall is combinational from registered state plus wbEn. It is asserted only in a forced-grant cycle, never two cycles in a row, because starveCnt clears on the grant.
- Reset mid-operation: queued entries are discarded with no write. Outputs take reset values in the cycle rst is sampled high and in every following cycle while it stays high.
- Simultaneous enqueue + dequeue with a non-full queue: both occur, and qCount is unchanged.

## Test plan
- Idle pass-through: queue empty; wbEn=1, wbAddr=8, wbData=0xDEADBEEF → same cycle rfWe=1, rfAddr=8, rfData=0xDEADBEEF, wbStall=0.
- Free-slot drain: accept mu (addr 9, 0x12345678) at cycle 0 with wbEn=0 → cycle 1 rfWe=1, rfAddr=9, rfData=0x12345678, qCount returns to 0 at cycle 2.
- Starvation (STARVE_MAX=4): enqueue one entry, then hold wbEn=1 continuously.
  - Cycles 1–4: WB written, starveCnt reaches 4.
  - Cycle 5: head written, wbStall=1.
  - Cycle 6: held WB written, wbStall=0.
- Full/backpressure (QDEPTH=2): two accepts with wbEn=1 → qCount=2, muReady=0. A third muValid is held until a dequeue has updated qCount; it is accepted the cycle after the dequeue edge.
- $0 handling: mu entry with addr 0 → rfWe=0 in its grant cycle and qCount decrements. WB write to $0 → rfWe=0, wbStall=0.
- Reset mid-drain: qCount=2, assert rst for one cycle → rfWe=0, qCount=0, muReady=0 during reset. The next cycle muReady=1 and no stale write occurs.
